mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Next-gen multi-cycle MIPS control FSM; drives datapath muxes/enables once per state.
//  Adds: mem_ready handshake on every memory state; resolved branch write (zero/!zero);
//  precise exceptions (invalid op, overflow, mult/div timeout) with EPC/cause and vector jump;
//  parametrised mult/div watchdog. Sits between IR decode fields and datapath/mem/muldiv.
// PARAMETERS
//  MD_TIMEOUT  64  max MD_WAIT cycles before timeout exception (>=2)
//  CNT_W       7   watchdog counter width; must hold MD_TIMEOUT
//  STATE_W     5   width of state_dbg
// PORTS
//  clk        in  1  clock
//  reset      in  1  asynchronous, active-high
//  opcode     in  6  IR[31:26];  funct  in  6  IR[5:0]
//  mem_ready  in  1  memory done this cycle (read data valid / write accepted)
//  alu_zero   in  1  ALU zero flag;  alu_ovf  in 1  ALU signed overflow
//  md_done    in  1  mult/div result valid (1-cycle pulse)
//  pc_write, ior_d, mem_read, mem_write, ir_write, reg_write  out 1 each
//  reg_dst    out 2  00 rt, 01 rd, 10 $31
//  alu_src_a  out 1  0 PC, 1 A;  alu_src_b  out 2  00 B, 01 +4, 10 imm, 11 imm<<2
//  alu_op     out 4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1100 lui
//  pc_source  out 3  000 ALU, 001 ALUOut, 010 jump tgt, 011 A(jr), 100 exc vector
//  wb_src     out 2  00 ALUOut, 01 MDR, 10 HI, 11 LO
//  hilo_write, mult_start, div_start, epc_write  out 1 each
//  cause      out 2  registered: 00 none, 01 overflow, 10 invalid op, 11 md timeout
//  state_dbg  out STATE_W  current state encoding
// BEHAVIOUR
//  Reset: state=FETCH, cause=00, counter=0; all comb outputs default 0 except alu_src_a=1.
//  FETCH: mem_read, alu_src_a=0, alu_src_b=01, alu_op=add; stay until mem_ready; in the
//   mem_ready cycle also ir_write=1, pc_write=1 -> DECODE. PC/IR never written without mem_ready.
//  DECODE: ALU = PC + imm<<2. Dispatch: R add/sub/and/or/slt->R_EXEC; jr->JUMP; mult->MULT;
//   div->DIV; mfhi->MFHI; mflo->MFLO; lw/sw->MEM_ADDR; addi/slti->I_EXEC; beq/bne->BRANCH;
//   lui->LUI; j->JUMP; jal->JAL; any other opcode/funct -> EXC with cause=10.
//  MEM_ADDR: A+imm -> LW_READ or SW_WRITE. LW_READ: mem_read, ior_d held until mem_ready
//   -> LW_WB (reg_write, rt, wb_src=01) -> FETCH. SW_WRITE: mem_write, ior_d held until
//   mem_ready -> FETCH. Address/data assumed stable by datapath across wait.
//  R_EXEC/I_EXEC/LUI -> WB (reg_write; rd for R, rt otherwise; wb_src=00) -> FETCH.
//  BRANCH: alu_op=sub, pc_source=001; pc_write = beq ? alu_zero : ~alu_zero. -> FETCH.
//  JUMP: pc_write, pc_source=010 (j) / 011 (jr). JAL: pc_write, pc_source=010, reg_write,
//   reg_dst=10, ALU recomputes PC+4 (src_a=0, src_b=01, add). Both -> FETCH.
//  MULT/DIV: one-cycle mult_start/div_start, counter<=0 -> MD_WAIT.
//  MD_WAIT: counter++ each cycle. md_done: hilo_write=1 -> FETCH (done wins over timeout
//   in same cycle). counter==MD_TIMEOUT-1 and !md_done -> EXC, cause=11.
//  MFHI/MFLO: reg_write, rd, wb_src=10/11 -> FETCH.
//  EXC: epc_write=1, pc_write=1, pc_source=100; cause held until next exception. -> FETCH.
//  md_done outside MD_WAIT ignored. mem_ready outside memory states ignored.
//  Reset mid-operation (any state, incl. waits): immediate return to FETCH, no writes.
// CONFIGURATION
//  OVF_TRAP_EN defined: in R_EXEC (add/sub) or I_EXEC (addi) with alu_ovf=1 -> EXC,
//   cause=01, no register write-back. Undefined: alu_ovf ignored, normal WB.
// TESTING
//  1 lw, mem_ready low 3 cycles in LW_READ -> mem_read held 4 cycles, reg_write exactly 1 cycle after.
//  2 beq alu_zero=0 -> pc_write=0; bne alu_zero=0 -> pc_write=1, pc_source=001.
//  3 mult, md_done never -> after 64 MD_WAIT cycles EXC: epc_write=1, pc_source=100, cause=11.
//  4 opcode 6'b111111 -> DECODE->EXC, cause=10, no reg_write/mem_write at any point.
//  5 OVF_TRAP_EN, add with alu_ovf=1 -> EXC cause=01, reg_write never 1; without macro -> WB.
//  6 reset asserted in SW_WRITE wait -> mem_write drops same cycle, state_dbg=FETCH, cause=00.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: memory handshakes, resolved branches, precise exceptions
// and a mult/div watchdog. Define OVF_TRAP_EN to trap signed overflow on add/sub/addi.
module mc_ctrl_fsm #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7,
  parameter int STATE_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  input  logic               alu_zero,
  input  logic               alu_ovf,
  input  logic               md_done,
  output logic               pc_write,
  output logic               ior_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         alu_op,
  output logic [2:0]         pc_source,
  output logic [1:0]         wb_src,
  output logic               hilo_write,
  output logic               mult_start,
  output logic               div_start,
  output logic               epc_write,
  output logic [1:0]         cause,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [4:0] {
    FETCH    = 5'd0,  DECODE = 5'd1,  MEM_ADDR = 5'd2,  LW_READ = 5'd3,
    LW_WB    = 5'd4,  SW_WRITE = 5'd5, R_EXEC = 5'd6,   I_EXEC  = 5'd7,
    LUI      = 5'd8,  WB     = 5'd9,  BRANCH   = 5'd10, JUMP    = 5'd11,
    JAL      = 5'd12, MULT   = 5'd13, DIV      = 5'd14, MD_WAIT = 5'd15,
    MFHI     = 5'd16, MFLO   = 5'd17, EXC      = 5'd18
  } state_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_J   = 6'b000010, OP_JAL  = 6'b000011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_SLTI = 6'b001010, OP_LUI = 6'b001111, OP_LW  = 6'b100011,
                         OP_SW = 6'b101011;
  localparam logic [5:0] F_JR = 6'b001000, F_MFHI = 6'b010000, F_MFLO = 6'b010010,
                         F_MULT = 6'b011000, F_DIV = 6'b011010, F_ADD  = 6'b100000,
                         F_SUB = 6'b100010, F_AND = 6'b100100, F_OR   = 6'b100101,
                         F_SLT = 6'b101010;
  localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000,
                         ALU_OR = 4'b0001, ALU_SLT = 4'b0111, ALU_LUI = 4'b1100;
  localparam logic [1:0] CAUSE_NONE = 2'b00, CAUSE_OVF = 2'b01, CAUSE_INV = 2'b10,
                         CAUSE_MDTO = 2'b11;
  localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] md_cnt;

  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
    state_t s;
    s = EXC;
    case (op)
      OP_R: case (fn)
        F_ADD, F_SUB, F_AND, F_OR, F_SLT: s = R_EXEC;
        F_JR:   s = JUMP;
        F_MULT: s = MULT;
        F_DIV:  s = DIV;
        F_MFHI: s = MFHI;
        F_MFLO: s = MFLO;
        default: s = EXC;
      endcase
      OP_LW, OP_SW:     s = MEM_ADDR;
      OP_ADDI, OP_SLTI: s = I_EXEC;
      OP_BEQ, OP_BNE:   s = BRANCH;
      OP_LUI:           s = LUI;
      OP_J:             s = JUMP;
      OP_JAL:           s = JAL;
      default:          s = EXC;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] r_alu_op(input logic [5:0] fn);
    case (fn)
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_SLT:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

`ifndef OVF_TRAP_EN
  logic ovf_unused;
  assign ovf_unused = alu_ovf;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FETCH;
      cause  <= CAUSE_NONE;
      md_cnt <= '0;
    end else begin
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          state <= dispatch(opcode, funct);
          if (dispatch(opcode, funct) == EXC) cause <= CAUSE_INV;
        end
        MEM_ADDR: state <= (opcode == OP_LW) ? LW_READ : SW_WRITE;
        LW_READ:  if (mem_ready) state <= LW_WB;
        SW_WRITE: if (mem_ready) state <= FETCH;
`ifdef OVF_TRAP_EN
        R_EXEC: begin
          if (alu_ovf && (funct == F_ADD || funct == F_SUB)) begin
            state <= EXC;
            cause <= CAUSE_OVF;
          end else begin
            state <= WB;
          end
        end
        I_EXEC: begin
          if (alu_ovf && opcode == OP_ADDI) begin
            state <= EXC;
            cause <= CAUSE_OVF;
          end else begin
            state <= WB;
          end
        end
`else
        R_EXEC, I_EXEC: state <= WB;
`endif
        LUI:       state <= WB;
        MULT, DIV: begin
          md_cnt <= '0;
          state  <= MD_WAIT;
        end
        MD_WAIT: begin
          md_cnt <= md_cnt + CNT_W'(1);
          // A completion arriving on the last allowed cycle still beats the watchdog.
          if (md_done) begin
            state <= FETCH;
          end else if (md_cnt == MD_LAST) begin
            state <= EXC;
            cause <= CAUSE_MDTO;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch can be inferred.
  always_comb begin
    pc_write   = 1'b0;
    ior_d      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    alu_src_a  = 1'b1;
    alu_src_b  = 2'b00;
    alu_op     = 4'b0000;
    pc_source  = 3'b000;
    wb_src     = 2'b00;
    hilo_write = 1'b0;
    mult_start = 1'b0;
    div_start  = 1'b0;
    epc_write  = 1'b0;
    // Reset must suppress every write strobe at once, even before the state flop settles.
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_a = 1'b0;
          alu_src_b = 2'b01;
          alu_op    = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_a = 1'b0;
          alu_src_b = 2'b11;
          alu_op    = ALU_ADD;
        end
        MEM_ADDR: begin
          alu_src_b = 2'b10;
          alu_op    = ALU_ADD;
        end
        LW_READ: begin
          mem_read = 1'b1;
          ior_d    = 1'b1;
        end
        LW_WB: begin
          reg_write = 1'b1;
          wb_src    = 2'b01;
        end
        SW_WRITE: begin
          mem_write = 1'b1;
          ior_d     = 1'b1;
        end
        R_EXEC: alu_op = r_alu_op(funct);
        I_EXEC: begin
          alu_src_b = 2'b10;
          alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        LUI: begin
          alu_src_b = 2'b10;
          alu_op    = ALU_LUI;
        end
        WB: begin
          reg_write = 1'b1;
          reg_dst   = (opcode == OP_R) ? 2'b01 : 2'b00;
        end
        BRANCH: begin
          alu_op    = ALU_SUB;
          pc_source = 3'b001;
          pc_write  = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = (opcode == OP_R) ? 3'b011 : 3'b010;
        end
        JAL: begin
          pc_write  = 1'b1;
          pc_source = 3'b010;
          reg_write = 1'b1;
          reg_dst   = 2'b10;
          alu_src_a = 1'b0;
          alu_src_b = 2'b01;
          alu_op    = ALU_ADD;
        end
        MULT:    mult_start = 1'b1;
        DIV:     div_start  = 1'b1;
        MD_WAIT: hilo_write = md_done;
        MFHI: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
          wb_src    = 2'b10;
        end
        MFLO: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
          wb_src    = 2'b11;
        end
        EXC: begin
          epc_write = 1'b1;
          pc_write  = 1'b1;
          pc_source = 3'b100;
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = STATE_W'(state);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: expectations are queued as stimulus is driven and
// drained against the DUT outputs on the falling edge of each cycle.
module tb_mc_ctrl_fsm;
  localparam int MD_TIMEOUT = 64;
  localparam logic [5:0] OP_R = 6'b000000, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                         OP_ADDI = 6'b001000, OP_JAL = 6'b000011, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BAD = 6'b111111;
  localparam logic [5:0] F_JR = 6'b001000, F_MFHI = 6'b010000, F_MULT = 6'b011000,
                         F_DIV = 6'b011010, F_ADD = 6'b100000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic mem_ready = 1'b0, alu_zero = 1'b0, alu_ovf = 1'b0, md_done = 1'b0;
  logic pc_write, ior_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, alu_src_b, wb_src, cause;
  logic alu_src_a;
  logic [3:0] alu_op;
  logic [2:0] pc_source;
  logic hilo_write, mult_start, div_start, epc_write;
  logic [4:0] state_dbg;

  mc_ctrl_fsm #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(7), .STATE_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf), .md_done(md_done), .pc_write(pc_write),
    .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .wb_src(wb_src), .hilo_write(hilo_write),
    .mult_start(mult_start), .div_start(div_start), .epc_write(epc_write), .cause(cause),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_PCW, S_IORD, S_MRD, S_MWR, S_IRW, S_RW, S_RDST, S_SRCA, S_SRCB, S_ALUOP,
    S_PCSRC, S_WB, S_HILO, S_MULS, S_DIVS, S_EPC, S_CAUSE, S_STATE
  } sel_e;

  typedef struct {
    string      name;
    sel_e       sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] obs(input sel_e s);
    case (s)
      S_PCW:   return 8'(pc_write);
      S_IORD:  return 8'(ior_d);
      S_MRD:   return 8'(mem_read);
      S_MWR:   return 8'(mem_write);
      S_IRW:   return 8'(ir_write);
      S_RW:    return 8'(reg_write);
      S_RDST:  return 8'(reg_dst);
      S_SRCA:  return 8'(alu_src_a);
      S_SRCB:  return 8'(alu_src_b);
      S_ALUOP: return 8'(alu_op);
      S_PCSRC: return 8'(pc_source);
      S_WB:    return 8'(wb_src);
      S_HILO:  return 8'(hilo_write);
      S_MULS:  return 8'(mult_start);
      S_DIVS:  return 8'(div_start);
      S_EPC:   return 8'(epc_write);
      S_CAUSE: return 8'(cause);
      default: return 8'(state_dbg);
    endcase
  endfunction

  task automatic check(input string name, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s", name);
    end
  endtask

  task automatic drain();
    exp_t       e;
    logic [7:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = obs(e.sel);
      check($sformatf("%s (got %0h, expected %0h)", e.name, got, e.val), got === e.val);
    end
  endtask

  task automatic cmp();
    @(negedge clk);
    drain();
  endtask

  task automatic ex(input string n, input sel_e s, input logic [7:0] v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic rdy, input logic zero, input logic ovf, input logic done);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    alu_zero  = zero;
    alu_ovf   = ovf;
    md_done   = done;
  endtask

  // Fetch with an immediate mem_ready, then sit in DECODE for one cycle.
  task automatic fetch_instr(input logic [5:0] op, input logic [5:0] fn);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    opcode = op;
    funct  = fn;
    ex("fetch_ir_write", S_IRW, 1);
    ex("fetch_pc_write", S_PCW, 1);
    ex("fetch_mem_read", S_MRD, 1);
    ex("fetch_src_b", S_SRCB, 1);
    cmp();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("decode_src_b", S_SRCB, 3);
    ex("decode_pc_write", S_PCW, 0);
    ex("decode_reg_write", S_RW, 0);
    ex("decode_mem_write", S_MWR, 0);
    cmp();
  endtask

  task automatic back_in_fetch(input string tag);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex({tag, "_state_fetch"}, S_STATE, 0);
    ex({tag, "_reg_write_off"}, S_RW, 0);
    ex({tag, "_epc_write_off"}, S_EPC, 0);
    cmp();
    check({tag, "_fetch_mem_read"}, mem_read === 1'b1);
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    #2;
    ex("rst_state", S_STATE, 0);
    ex("rst_cause", S_CAUSE, 0);
    ex("rst_src_a", S_SRCA, 1);
    ex("rst_ir_write", S_IRW, 0);
    ex("rst_pc_write", S_PCW, 0);
    ex("rst_mem_read", S_MRD, 0);
    cmp();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    mem_ready = 1'b0;
    ex("fetch_wait_mem_read", S_MRD, 1);
    ex("fetch_wait_ir_write", S_IRW, 0);
    ex("fetch_wait_pc_write", S_PCW, 0);
    ex("fetch_wait_src_a", S_SRCA, 0);
    cmp();
    check("fetch_wait_state", state_dbg === 5'd0);
  endtask

  task automatic test_lw_wait();
    fetch_instr(OP_LW, 6'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("memaddr_src_b", S_SRCB, 2);
    ex("memaddr_src_a", S_SRCA, 1);
    cmp();
    for (int i = 0; i < 4; i++) begin
      drive(i == 3, 1'b0, 1'b0, 1'b0);
      ex("lw_read_mem_read", S_MRD, 1);
      ex("lw_read_ior_d", S_IORD, 1);
      ex("lw_read_reg_write", S_RW, 0);
      cmp();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("lw_wb_reg_write", S_RW, 1);
    ex("lw_wb_reg_dst", S_RDST, 0);
    ex("lw_wb_wb_src", S_WB, 1);
    ex("lw_wb_mem_read", S_MRD, 0);
    cmp();
    back_in_fetch("lw_done");
  endtask

  task automatic test_branch();
    logic [5:0] ops [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
    logic       zs  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       pcw [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      fetch_instr(ops[i], 6'd0);
      drive(1'b0, zs[i], 1'b0, 1'b0);
      ex($sformatf("branch%0d_pc_write", i), S_PCW, 8'(pcw[i]));
      ex($sformatf("branch%0d_pc_source", i), S_PCSRC, 1);
      ex($sformatf("branch%0d_alu_op", i), S_ALUOP, 6);
      cmp();
      back_in_fetch("branch");
    end
  endtask

  task automatic test_md_timeout();
    fetch_instr(OP_R, F_MULT);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("mult_start", S_MULS, 1);
    ex("mult_div_start", S_DIVS, 0);
    cmp();
    for (int i = 0; i < MD_TIMEOUT; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      ex($sformatf("md_wait%0d_epc", i), S_EPC, 0);
      ex($sformatf("md_wait%0d_hilo", i), S_HILO, 0);
      cmp();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("md_to_epc_write", S_EPC, 1);
    ex("md_to_pc_write", S_PCW, 1);
    ex("md_to_pc_source", S_PCSRC, 4);
    ex("md_to_cause", S_CAUSE, 3);
    cmp();
    check("md_to_no_hilo_write", hilo_write === 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("md_to_fetch_state", S_STATE, 0);
    ex("md_to_cause_held", S_CAUSE, 3);
    cmp();
  endtask

  task automatic test_md_done();
    fetch_instr(OP_R, F_DIV);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("div_start", S_DIVS, 1);
    cmp();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, i == 2);
      ex($sformatf("div_wait%0d_hilo", i), S_HILO, 8'(i == 2));
      cmp();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    ex("done_in_fetch_hilo", S_HILO, 0);
    ex("done_in_fetch_state", S_STATE, 0);
    cmp();
    // md_done on the last watchdog cycle must complete normally.
    fetch_instr(OP_R, F_MULT);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cmp();
    for (int i = 0; i < MD_TIMEOUT; i++) begin
      drive(1'b0, 1'b0, 1'b0, i == MD_TIMEOUT - 1);
      ex($sformatf("edge_wait%0d_hilo", i), S_HILO, 8'(i == MD_TIMEOUT - 1));
      ex($sformatf("edge_wait%0d_epc", i), S_EPC, 0);
      cmp();
    end
    back_in_fetch("edge_done");
  endtask

  task automatic test_invalid_op();
    fetch_instr(OP_BAD, 6'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("inv_epc_write", S_EPC, 1);
    ex("inv_pc_source", S_PCSRC, 4);
    ex("inv_cause", S_CAUSE, 2);
    ex("inv_reg_write", S_RW, 0);
    ex("inv_mem_write", S_MWR, 0);
    cmp();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("inv_fetch_state", S_STATE, 0);
    ex("inv_fetch_cause", S_CAUSE, 2);
    ex("inv_fetch_mem_write", S_MWR, 0);
    cmp();
    check("inv_fetch_no_reg_write", reg_write === 1'b0);
  endtask

  task automatic test_overflow();
    fetch_instr(OP_R, F_ADD);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    ex("rexec_alu_op", S_ALUOP, 2);
    ex("rexec_src_b", S_SRCB, 0);
    ex("rexec_reg_write", S_RW, 0);
    cmp();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef OVF_TRAP_EN
    ex("ovf_epc_write", S_EPC, 1);
    ex("ovf_cause", S_CAUSE, 1);
    ex("ovf_reg_write", S_RW, 0);
`else
    ex("ovf_wb_reg_write", S_RW, 1);
    ex("ovf_wb_reg_dst", S_RDST, 1);
    ex("ovf_wb_epc_write", S_EPC, 0);
`endif
    cmp();
    back_in_fetch("ovf");
    fetch_instr(OP_ADDI, 6'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("addi_src_b", S_SRCB, 2);
    ex("addi_alu_op", S_ALUOP, 2);
    cmp();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("addi_wb_reg_write", S_RW, 1);
    ex("addi_wb_reg_dst", S_RDST, 0);
    cmp();
    back_in_fetch("addi");
  endtask

  task automatic test_jumps();
    fetch_instr(OP_JAL, 6'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("jal_pc_write", S_PCW, 1);
    ex("jal_pc_source", S_PCSRC, 2);
    ex("jal_reg_write", S_RW, 1);
    ex("jal_reg_dst", S_RDST, 2);
    ex("jal_src_a", S_SRCA, 0);
    ex("jal_src_b", S_SRCB, 1);
    cmp();
    back_in_fetch("jal");
    fetch_instr(OP_R, F_JR);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("jr_pc_write", S_PCW, 1);
    ex("jr_pc_source", S_PCSRC, 3);
    cmp();
    back_in_fetch("jr");
    fetch_instr(OP_R, F_MFHI);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("mfhi_reg_write", S_RW, 1);
    ex("mfhi_reg_dst", S_RDST, 1);
    ex("mfhi_wb_src", S_WB, 2);
    cmp();
    back_in_fetch("mfhi");
  endtask

  task automatic test_reset_in_sw();
    fetch_instr(OP_SW, 6'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cmp();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ex("sw_wait_mem_write", S_MWR, 1);
    ex("sw_wait_ior_d", S_IORD, 1);
    ex("sw_cause_before_reset", S_CAUSE, 2);
    cmp();
    #2;
    reset = 1'b1;
    #1;
    ex("sw_rst_mem_write", S_MWR, 0);
    ex("sw_rst_state", S_STATE, 0);
    ex("sw_rst_cause", S_CAUSE, 0);
    drain();
    check("sw_rst_ior_d", ior_d === 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ex("sw_post_rst_mem_read", S_MRD, 1);
    ex("sw_post_rst_mem_write", S_MWR, 0);
    ex("sw_post_rst_state", S_STATE, 0);
    cmp();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw_wait();
    test_branch();
    test_md_timeout();
    test_md_done();
    test_overflow();
    test_jumps();
    test_invalid_op();
    test_reset_in_sw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
